// File: rtl/ccff_loader.sv
// Configuration-chain loader: serializes handshaked words onto ccff_head, gates the chain
// shift enable so a load moves exactly CHAIN_LEN positions, and returns the bits leaving ccff_tail.
module ccff_loader #(
  parameter int unsigned CHAIN_LEN = 28,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              i_prog_clk,
  input  logic              i_pReset,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_cfg_word,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  output logic              o_ccff_head,
  input  logic              i_ccff_tail,
  output logic              o_cfg_clk_en,
  output logic [WORD_W-1:0] o_rb_word,
  output logic              o_rb_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int unsigned CW        = $clog2(CHAIN_LEN + 1);
  localparam int unsigned NWW       = $clog2(NW + 1);
  localparam int unsigned IW        = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CW-1:0]  LC_CHAIN_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [NWW-1:0] LC_NW         = NWW'(NW);
  localparam logic [NWW-1:0] LC_NW_LAST    = NWW'(NW - 1);
  localparam logic [IW-1:0]  LC_WORD_LAST  = IW'(WORD_W - 1);
  localparam logic [IW-1:0]  LC_PART_LAST  = IW'(LAST_BITS - 1);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e             r_state, w_state_d;
  logic [WORD_W-1:0]  r_buf, w_buf_d;
  logic [IW-1:0]      r_idx, w_idx_d;
  logic [IW-1:0]      r_last, w_last_d;
  logic               r_live, w_live_d;
  logic [NWW-1:0]     r_words, w_words_d;
  logic [CW-1:0]      r_cnt, w_cnt_d;
  logic [WORD_W-1:0]  r_rb_sr, w_rb_sr_d;
  logic [IW-1:0]      r_rb_cnt, w_rb_cnt_d;

  logic               r_cfg_ready, w_cfg_ready_d;
  logic               r_ccff_head, w_ccff_head_d;
  logic               r_cfg_clk_en, w_cfg_clk_en_d;
  logic [WORD_W-1:0]  r_rb_word, w_rb_word_d;
  logic               r_rb_valid, w_rb_valid_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;

  logic               w_accept;
  logic               w_shift;
  logic               w_chain_end;

  always_comb begin
    w_accept    = r_cfg_ready & i_cfg_valid;
    w_shift     = r_cfg_clk_en;
    w_chain_end = w_shift & (r_cnt == LC_CHAIN_LAST);

    w_state_d    = r_state;
    w_buf_d      = r_buf;
    w_idx_d      = r_idx;
    w_last_d     = r_last;
    w_live_d     = r_live;
    w_words_d    = r_words;
    w_cnt_d      = r_cnt;
    w_rb_sr_d    = r_rb_sr;
    w_rb_cnt_d   = r_rb_cnt;
    w_rb_word_d  = r_rb_word;
    w_rb_valid_d = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d  = StShift;
          w_live_d   = 1'b0;
          w_idx_d    = '0;
          w_words_d  = '0;
          w_cnt_d    = '0;
          w_rb_sr_d  = '0;
          w_rb_cnt_d = '0;
        end
      end
      StShift: begin
        if (w_shift) begin
          w_cnt_d              = r_cnt + 1'b1;
          w_rb_sr_d[r_rb_cnt]  = i_ccff_tail;
          // The final sample of a load flushes whatever is collected, zero-padded above.
          if (r_rb_cnt == LC_WORD_LAST || w_chain_end) begin
            w_rb_word_d  = w_rb_sr_d;
            w_rb_valid_d = 1'b1;
            w_rb_sr_d    = '0;
            w_rb_cnt_d   = '0;
          end else begin
            w_rb_cnt_d = r_rb_cnt + 1'b1;
          end
        end
        if (w_chain_end) begin
          w_state_d = StFinish;
        end
        if (w_accept) begin
          w_buf_d   = i_cfg_word;
          w_idx_d   = '0;
          w_live_d  = 1'b1;
          w_last_d  = (r_words == LC_NW_LAST) ? LC_PART_LAST : LC_WORD_LAST;
          w_words_d = r_words + 1'b1;
        end else if (w_shift && (r_idx == r_last)) begin
          w_live_d = 1'b0;
        end else if (w_shift) begin
          w_idx_d = r_idx + 1'b1;
        end
      end
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase

    // Outputs are precomputed from next state so every port comes straight from a flop.
    w_cfg_clk_en_d = (w_state_d == StShift) & w_live_d;
    w_ccff_head_d  = w_cfg_clk_en_d & w_buf_d[w_idx_d];
    w_cfg_ready_d  = (w_state_d == StShift) & (w_words_d != LC_NW) &
                     (~w_live_d | (w_idx_d == w_last_d));
    w_busy_d       = (w_state_d == StShift);
    w_done_d       = (w_state_d == StFinish);
  end

  always_ff @(posedge i_prog_clk or posedge i_pReset) begin
    if (i_pReset) begin
      r_state      <= StIdle;
      r_buf        <= '0;
      r_idx        <= '0;
      r_last       <= '0;
      r_live       <= 1'b0;
      r_words      <= '0;
      r_cnt        <= '0;
      r_rb_sr      <= '0;
      r_rb_cnt     <= '0;
      r_cfg_ready  <= 1'b0;
      r_ccff_head  <= 1'b0;
      r_cfg_clk_en <= 1'b0;
      r_rb_word    <= '0;
      r_rb_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_buf        <= w_buf_d;
      r_idx        <= w_idx_d;
      r_last       <= w_last_d;
      r_live       <= w_live_d;
      r_words      <= w_words_d;
      r_cnt        <= w_cnt_d;
      r_rb_sr      <= w_rb_sr_d;
      r_rb_cnt     <= w_rb_cnt_d;
      r_cfg_ready  <= w_cfg_ready_d;
      r_ccff_head  <= w_ccff_head_d;
      r_cfg_clk_en <= w_cfg_clk_en_d;
      r_rb_word    <= w_rb_word_d;
      r_rb_valid   <= w_rb_valid_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
    end
  end

  assign o_cfg_ready  = r_cfg_ready;
  assign o_ccff_head  = r_ccff_head;
  assign o_cfg_clk_en = r_cfg_clk_en;
  assign o_rb_word    = r_rb_word;
  assign o_rb_valid   = r_rb_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: drives loads against a 28-bit chain model and checks the serial
// stream, enable gating, readback words and handshake timing.
module tb_ccff_loader;

  logic        clk;
  logic        i_pReset;
  logic        i_start;
  logic [7:0]  i_cfg_word;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic        o_ccff_head;
  logic        w_tail;
  logic        o_cfg_clk_en;
  logic [7:0]  o_rb_word;
  logic        o_rb_valid;
  logic        o_busy;
  logic        o_done;

  ccff_loader #(.CHAIN_LEN(28), .WORD_W(8)) dut (
    .i_prog_clk   (clk),
    .i_pReset     (i_pReset),
    .i_start      (i_start),
    .i_cfg_word   (i_cfg_word),
    .i_cfg_valid  (i_cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .o_ccff_head  (o_ccff_head),
    .i_ccff_tail  (w_tail),
    .o_cfg_clk_en (o_cfg_clk_en),
    .o_rb_word    (o_rb_word),
    .o_rb_valid   (o_rb_valid),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream chain model: tail is bit 0, head enters at bit 27.
  logic [27:0] chain;
  logic [27:0] preload_val;
  logic        preload_req;
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (o_cfg_clk_en === 1'b1) chain <= {o_ccff_head, chain[27:1]};
  end
  assign w_tail = chain[0];

  // Per-load observations, cleared when a start is seen in IDLE.
  int          en_cnt, first_en, last_en, rb_n, done_n, done_cyc, acc, c_start, idle_acc;
  logic [27:0] hv;
  logic [31:0] rbw;
  logic        rb_at_done;
  logic [1:0]  b1;

  initial begin
    idle_acc = 0;
    en_cnt = 0; acc = 0; done_n = 0; rb_n = 0; c_start = 0;
    forever begin
      @(negedge clk);
      if (i_start === 1'b1 && o_busy !== 1'b1 && o_done !== 1'b1 && i_pReset === 1'b0) begin
        en_cnt = 0; first_en = 0; last_en = 0; rb_n = 0; done_n = 0; done_cyc = 0;
        acc = 0; hv = '0; rbw = '0; rb_at_done = 1'b0; b1 = 2'b00; c_start = cyc;
      end
      if (cyc == c_start + 1) b1 = {o_busy, o_cfg_ready};
      if (o_cfg_clk_en === 1'b1) begin
        if (en_cnt == 0) first_en = cyc;
        last_en = cyc;
        if (en_cnt < 28) hv[en_cnt] = o_ccff_head;
        en_cnt++;
      end
      if (o_rb_valid === 1'b1) begin
        if (rb_n < 4) rbw[rb_n*8 +: 8] = o_rb_word;
        rb_n++;
        if (o_done === 1'b1) rb_at_done = 1'b1;
      end
      if (o_done === 1'b1) begin
        done_n++;
        done_cyc = cyc;
      end
      if (o_cfg_ready === 1'b1 && i_cfg_valid === 1'b1) begin
        acc++;
        if (o_busy !== 1'b1) idle_acc++;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [27:0] v);
    @(posedge clk); #1;
    preload_val = v;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  // Words packed {w3,w2,w1,w0}; stall drops valid while the third word is wanted.
  task automatic run_load(input logic [31:0] words, input int stall, input bit mid_start,
                          input int abort_at, output bit timed_out);
    int sd = 0;
    @(posedge clk); #1;
    i_start     = 1'b1;
    i_cfg_valid = 1'b1;
    i_cfg_word  = words[7:0];
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      i_start = mid_start && (n == 10);
      if (abort_at != 0 && en_cnt >= abort_at) begin
        @(negedge clk); #2;
        i_pReset = 1'b1;
        break;
      end
      if (acc >= 4) begin
        i_cfg_valid = 1'b0;
      end else begin
        i_cfg_word = words[acc*8 +: 8];
        if (acc == 2 && o_cfg_ready && sd < stall) begin
          i_cfg_valid = 1'b0;
          sd++;
        end else begin
          i_cfg_valid = 1'b1;
        end
      end
      if (done_n != 0) break;
    end
    i_start     = 1'b0;
    i_cfg_valid = 1'b0;
    timed_out   = (abort_at == 0) && (done_n == 0);
  endtask

  typedef struct {
    logic [31:0] words;
    logic [27:0] pre;
    int          stall;
    bit          mid_start;
    int          exp_span;
    logic [27:0] exp_chain;
    logic [31:0] exp_rb;
  } vec_t;

  vec_t vecs[4];
  bit   to;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_pReset = 1'b0; i_start = 1'b0; i_cfg_valid = 1'b0; i_cfg_word = '0;
    preload_req = 1'b0; preload_val = '0;

    vecs[0] = '{32'h09FF3CA5, 28'h0000000, 0, 1'b0, 28, 28'h9FF3CA5, 32'h00000000};
    vecs[1] = '{32'h09FF3CA5, 28'hDEADBEE, 0, 1'b0, 28, 28'h9FF3CA5, 32'h0DEADBEE};
    vecs[2] = '{32'h09FF3CA5, 28'hDEADBEE, 5, 1'b0, 33, 28'h9FF3CA5, 32'h0DEADBEE};
    vecs[3] = '{32'hA7563412, 28'h1234567, 0, 1'b1, 28, 28'h7563412, 32'h01234567};

    // Asynchronous reset between edges from an unreset state.
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    i_pReset = 1'b1;
    #1;
    chk("reset_ctl", {o_cfg_ready, o_ccff_head, o_cfg_clk_en, o_rb_valid, o_busy, o_done}, 0);
    chk("reset_rb_word", o_rb_word, 0);
    @(negedge clk); #2;
    i_pReset = 1'b0;

    // Words offered in IDLE are refused.
    i_cfg_valid = 1'b1;
    i_cfg_word  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("idle_ready", o_cfg_ready, 0);
    end
    i_cfg_valid = 1'b0;

    for (int v = 0; v < 4; v++) begin
      preload(vecs[v].pre);
      run_load(vecs[v].words, vecs[v].stall, vecs[v].mid_start, 0, to);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_timeout", v), to, 0);
      chk($sformatf("v%0d_cycle1_busy_ready", v), b1, 2'b11);
      chk($sformatf("v%0d_first_en", v), first_en - c_start, 2);
      chk($sformatf("v%0d_en_count", v), en_cnt, 28);
      chk($sformatf("v%0d_en_span", v), last_en - first_en + 1, vecs[v].exp_span);
      chk($sformatf("v%0d_head_bits", v), hv, vecs[v].exp_chain);
      chk($sformatf("v%0d_chain", v), chain, vecs[v].exp_chain);
      chk($sformatf("v%0d_done_count", v), done_n, 1);
      chk($sformatf("v%0d_done_timing", v), done_cyc - last_en, 1);
      chk($sformatf("v%0d_rb_count", v), rb_n, 4);
      chk($sformatf("v%0d_rb_words", v), rbw, vecs[v].exp_rb);
      chk($sformatf("v%0d_rb_last_at_done", v), rb_at_done, 1);
      chk($sformatf("v%0d_words_accepted", v), acc, 4);
      chk($sformatf("v%0d_idle_after", v), {o_busy, o_cfg_ready, o_cfg_clk_en}, 0);
    end

    // Reset while bit 13 is on the head, then a clean reload.
    preload(28'hDEADBEE);
    run_load(32'h09FF3CA5, 0, 1'b0, 13, to);
    #1;
    chk("midrst_ctl", {o_cfg_ready, o_ccff_head, o_cfg_clk_en, o_rb_valid, o_busy, o_done}, 0);
    chk("midrst_rb_word", o_rb_word, 0);
    @(negedge clk); #2;
    i_pReset = 1'b0;
    @(negedge clk); #1;
    chk("midrst_idle", {o_busy, o_cfg_ready}, 0);
    run_load(32'h09FF3CA5, 0, 1'b0, 0, to);
    repeat (2) @(negedge clk);
    chk("reload_timeout", to, 0);
    chk("reload_en_count", en_cnt, 28);
    chk("reload_en_span", last_en - first_en + 1, 28);
    chk("reload_chain", chain, 28'h9FF3CA5);
    chk("reload_done_count", done_n, 1);

    chk("idle_accepts", idle_acc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader that drives the `ccff_head` input of a tile's configuration flip-flop chain, such as a switch-block memory chain made of 2-bit mux memories. It accepts configuration words over a valid/ready handshake and serializes them onto `ccff_head`, one bit per enabled `prog_clk` cycle. It gates the chain's shifting through a clock-enable output so the chain moves exactly `CHAIN_LEN` positions per load. It also captures the bits emerging from `ccff_tail` and returns the previous chain contents as readback words.

## Interface
- `CHAIN_LEN`, default 28: number of flip-flops in the downstream chain (14 muxes × 2 bits); minimum 1.
- `WORD_W`, default 8: configuration and readback word width; minimum 1.
- `prog_clk` in 1: configuration clock.
- `pReset` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to begin a load; sampled in IDLE only.
- `cfg_word` in `WORD_W`: configuration data; bit 0 is shifted first.
- `cfg_valid` in 1: `cfg_word` is valid.
- `cfg_ready` out 1: loader accepts `cfg_word` this cycle.
- `ccff_head` out 1: serial data into the chain.
- `ccff_tail` in 1: serial data out of the chain.
- `cfg_clk_en` out 1: chain shift enable (feeds the chain's clock gate).
- `rb_word` out `WORD_W`: readback word; bit 0 is the first bit sampled.
- `rb_valid` out 1: one-cycle pulse; `rb_word` is valid.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse when the load completes.

## Operation
- The FSM has three states: IDLE, SHIFT and FINISH.
  - IDLE → SHIFT on `start`.
  - SHIFT → FINISH after the `CHAIN_LEN`-th enabled cycle.
  - FINISH → IDLE unconditionally after one cycle.
- Words required per load: `NW = ceil(CHAIN_LEN/WORD_W)`. Of the last word, only the low `CHAIN_LEN - (NW-1)*WORD_W` bits are shifted; the upper bits are discarded.
- Buffering: one word register, a bit index and a shifted-bit counter of width `clog2(CHAIN_LEN+1)`.
- `cfg_ready` = SHIFT && words_accepted < NW && (buffer empty || the buffer's last live bit is being shifted this cycle).
  - With `cfg_valid` held high, there are no bubbles between words.
- `cfg_clk_en` is 1 only in SHIFT cycles where the buffer holds a live bit. If the buffer is empty, `cfg_clk_en` = 0 and the chain holds its state (a stall); the shifted-bit counter does not advance.
- On each enabled cycle, `ccff_tail` is sampled into the readback shift register.
  - After `WORD_W` samples, `rb_word` updates and `rb_valid` pulses.
  - A final partial word is zero-padded in the upper bits and reported with `rb_valid` in the FINISH cycle.
  - Readback has no backpressure; the consumer must take each pulse.
- FINISH: `done`=1 and `busy`=0 for one cycle; all other outputs are idle.
- `start` asserted while not in IDLE is ignored.
- Words offered while in IDLE or FINISH are not accepted (`cfg_ready`=0).
- Reset, including mid-load, gives IDLE, with:
  - `cfg_ready`, `ccff_head`, `cfg_clk_en`, `rb_valid`, `busy` and `done` all 0;
  - `rb_word` = 0;
  - counters and buffers cleared.
- After a mid-load reset the chain contents are undefined; software must reload.

## Timing
- All outputs are registered. `ccff_head` and `cfg_clk_en` change together. The chain captures `ccff_head` at the rising edge that ends an enabled cycle. `ccff_tail` is sampled at that same edge (its pre-shift value).
- `start` high at edge 0 → `busy`=1 and `cfg_ready`=1 from cycle 1.
- A word accepted at edge t → its bit 0 is on `ccff_head` with `cfg_clk_en`=1 in cycle t+1.
- With continuous `cfg_valid`, the load is a contiguous run of `CHAIN_LEN` enabled cycles, starting in cycle 2 when the first word is accepted at edge 1. `done` pulses in the cycle after the last enabled cycle.
- Full-word `rb_valid` pulses in the cycle after the `WORD_W`-th sample.
- With `CHAIN_LEN`=28 and contiguous shifting, the old chain bit k (counted from the tail) appears in readback position k.

## Test plan
- Reset: assert `pReset` asynchronously between clock edges → all outputs 0 immediately; `cfg_ready`=0 while in IDLE.
- Full load, defaults, words 0xA5, 0x3C, 0xFF, 0x09 with `cfg_valid` held high → exactly 28 cycles with `cfg_clk_en`=1, contiguous. The bit sequence on `ccff_head` is A5, 3C, FF (LSB-first), then 1,0,0,1. The upper nibble of 0x09 is not shifted. `done` pulses once.
- Readback: preload the chain model with 0xDEADBEE (28 bits), then load → `rb_word` pulses 0xEE, 0xDB, 0xEA, then 0x0D padded in the FINISH cycle.
- Stall: drop `cfg_valid` for 5 cycles after the second word → `cfg_clk_en`=0 for those cycles, the chain model is unchanged, and the final chain contents are identical to the unstalled run.
- Reset at bit 13 of a load → the block is back in IDLE. A `start` followed by a full load then completes normally with 28 enabled cycles.
- `start` pulsed during SHIFT, and `cfg_valid` asserted while in IDLE → ignored: the load length stays 28 and no word is accepted in IDLE.
